// File: rtl/calc_key_sequencer.sv
// Keypad operand-entry sequencer for the combinational calculator.
// Builds decimal operands a/b and an opcode from key events, evaluates by
// sampling the calculator's result, chains results and locks out on error.
module calc_key_sequencer #(
   parameter int unsigned DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  key_valid,
   input  logic [3:0]            key_code,
   output logic [DATA_WIDTH-1:0] a,
   output logic [DATA_WIDTH-1:0] b,
   output logic [1:0]            op,
   input  logic [DATA_WIDTH-1:0] calc_result,
   input  logic                  calc_invalid,
   output logic [DATA_WIDTH-1:0] display,
   output logic                  error
);

   typedef enum logic [1:0] {ENTER_A, ENTER_B, SHOW, ERR} state_t;

   localparam int unsigned AW = DATA_WIDTH + 4;

   state_t                  state_q, state_d;
   logic [DATA_WIDTH-1:0]   a_q, a_d;
   logic [DATA_WIDTH-1:0]   b_q, b_d;
   logic [1:0]              op_q, op_d;
   logic                    b_started_q, b_started_d;
   logic [DATA_WIDTH-1:0]   display_q, display_d;

   logic                    is_digit, is_op, is_eq, is_clear;
   logic [1:0]              op_code;
   logic [DATA_WIDTH-1:0]   digit_val;
   logic [DATA_WIDTH-1:0]   acc_src, acc_res;
   logic [AW-1:0]           acc_new;

   // Key decode and digit accumulation (acc*10+d, dropped when it overflows)
   always_comb begin
      is_digit  = (key_code <= 4'd9);
      is_op     = (key_code >= 4'd10) && (key_code <= 4'd13);
      is_eq     = (key_code == 4'd14);
      is_clear  = (key_code == 4'd15);
      // code-10 for 10..13 reduces to low two bits plus 2 (mod 4)
      op_code   = key_code[1:0] + 2'd2;
      digit_val = {{(DATA_WIDTH-4){1'b0}}, key_code};
      acc_src   = (state_q == ENTER_B) ? b_q : a_q;
      acc_new   = {4'b0000, acc_src} * AW'(10) + AW'(key_code);
      acc_res   = (acc_new[AW-1:DATA_WIDTH] == '0) ? acc_new[DATA_WIDTH-1:0] : acc_src;
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ENTER_A;
         a_q         <= '0;
         b_q         <= '0;
         op_q        <= 2'b00;
         b_started_q <= 1'b0;
         display_q   <= '0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         op_q        <= op_d;
         b_started_q <= b_started_d;
         display_q   <= display_d;
      end
   end

   // Next-state selection
   always_comb begin
      state_d = state_q;
      if (key_valid) begin
         if (is_clear) begin
            state_d = ENTER_A;
         end else begin
            case (state_q)
               ENTER_A: if (is_op) state_d = ENTER_B;
               ENTER_B: begin
                  if (is_eq || (is_op && b_started_q)) begin
                     if (calc_invalid) state_d = ERR;
                     else if (is_eq)   state_d = SHOW;
                     else              state_d = ENTER_B;
                  end
               end
               SHOW: begin
                  if (is_digit)   state_d = ENTER_A;
                  else if (is_op) state_d = ENTER_B;
               end
               default: state_d = state_q;
            endcase
         end
      end
   end

   // Operand, opcode and display updates per key
   always_comb begin
      a_d         = a_q;
      b_d         = b_q;
      op_d        = op_q;
      b_started_d = b_started_q;
      display_d   = display_q;
      if (key_valid) begin
         if (is_clear) begin
            a_d         = '0;
            b_d         = '0;
            op_d        = 2'b00;
            b_started_d = 1'b0;
            display_d   = '0;
         end else begin
            case (state_q)
               ENTER_A: begin
                  if (is_digit) begin
                     a_d       = acc_res;
                     display_d = acc_res;
                  end else if (is_op) begin
                     op_d        = op_code;
                     b_d         = '0;
                     b_started_d = 1'b0;
                  end else if (is_eq) begin
                     display_d = a_q;
                  end
               end
               ENTER_B: begin
                  if (is_digit) begin
                     b_d         = acc_res;
                     b_started_d = 1'b1;
                     display_d   = acc_res;
                  end else if (is_op && !b_started_q) begin
                     op_d = op_code;
                  end else if (is_op || is_eq) begin
                     // b is already zero when no digit was typed, so the
                     // calculator is evaluating with b=0 in that case
                     if (calc_invalid) begin
                        display_d = '0;
                     end else begin
                        a_d       = calc_result;
                        display_d = calc_result;
                        if (is_op) begin
                           b_d         = '0;
                           b_started_d = 1'b0;
                           op_d        = op_code;
                        end
                     end
                  end
               end
               SHOW: begin
                  if (is_digit) begin
                     a_d       = digit_val;
                     b_d       = '0;
                     display_d = digit_val;
                  end else if (is_op) begin
                     op_d        = op_code;
                     b_d         = '0;
                     b_started_d = 1'b0;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // Outputs driven straight from registers
   always_comb begin
      a       = a_q;
      b       = b_q;
      op      = op_q;
      display = display_q;
      error   = (state_q == ERR);
   end

endmodule

// File: tb/tb_calc_key_sequencer.sv
// Directed bench for calc_key_sequencer: a calculator stand-in drives
// calc_result/calc_invalid, and a key-level model predicts every output.
module tb_calc_key_sequencer;

   localparam int unsigned DW   = 16;
   localparam longint      MASK = (64'd1 << DW) - 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          key_valid = 1'b0;
   logic [3:0]    key_code = 4'd0;
   logic [DW-1:0] a, b, display, calc_result;
   logic [1:0]    op;
   logic          calc_invalid, error;

   int errors = 0;
   int checks = 0;
   bit check_en = 1'b0;

   // Model state (mode: 0 entering a, 1 entering b, 2 showing result, 3 error)
   int     m_mode;
   longint m_a, m_b, m_disp;
   int     m_op;
   bit     m_bst;

   calc_key_sequencer #(.DATA_WIDTH(DW)) dut (
      .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
      .a(a), .b(b), .op(op), .calc_result(calc_result),
      .calc_invalid(calc_invalid), .display(display), .error(error)
   );

   always #5 clk = ~clk;

   // Calculator stand-in
   always_comb begin
      calc_invalid = 1'b0;
      case (op)
         2'b00: calc_result = a + b;
         2'b01: calc_result = a - b;
         2'b10: calc_result = a * b;
         default: begin
            calc_invalid = (b == '0);
            calc_result  = (b == '0) ? '0 : a / b;
         end
      endcase
   end

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode = 0; m_a = 0; m_b = 0; m_op = 0; m_bst = 0; m_disp = 0;
   endtask

   function automatic longint accum(input longint acc, input int d);
      longint n = acc * 10 + d;
      return (n > MASK) ? acc : n;
   endfunction

   task automatic model_eval(input int c);
      longint r;
      bit bad = 0;
      case (m_op)
         0: r = (m_a + m_b) & MASK;
         1: r = (m_a - m_b) & MASK;
         2: r = (m_a * m_b) & MASK;
         default: if (m_b == 0) bad = 1; else r = m_a / m_b;
      endcase
      if (bad) begin
         m_mode = 3; m_disp = 0;
      end else begin
         m_a = r; m_disp = r;
         if (c == 14) m_mode = 2;
         else begin m_b = 0; m_bst = 0; m_op = c - 10; end
      end
   endtask

   task automatic model_key(input int c);
      if (c == 15) begin model_reset(); return; end
      case (m_mode)
         0: if (c <= 9) begin m_a = accum(m_a, c); m_disp = m_a; end
            else if (c <= 13) begin m_op = c - 10; m_b = 0; m_bst = 0; m_mode = 1; end
            else m_disp = m_a;
         1: if (c <= 9) begin m_b = accum(m_b, c); m_bst = 1; m_disp = m_b; end
            else if (c <= 13 && !m_bst) m_op = c - 10;
            else model_eval(c);
         2: if (c <= 9) begin m_a = c; m_b = 0; m_disp = c; m_mode = 0; end
            else if (c <= 13) begin m_op = c - 10; m_b = 0; m_bst = 0; m_mode = 1; end
         default: ;
      endcase
   endtask

   task automatic press(input int c);
      key_valid = 1'b1;
      key_code  = 4'(c);
      @(posedge clk);
      model_key(c);
      #1 key_valid = 1'b0;
   endtask

   // Every-cycle comparison against the model
   always @(negedge clk) begin
      if (check_en) begin
         chk("a", a, m_a);
         chk("b", b, m_b);
         chk("op", op, m_op);
         chk("display", display, m_disp);
         chk("error", error, (m_mode == 3));
      end
   end

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      check_en = 1'b1;
      chk("rst_a", a, 0);
      chk("rst_disp", display, 0);
      chk("rst_err", error, 0);
      chk("rst_op", op, 0);

      // 12 + 34 =
      press(1); press(2); chk("disp12", display, 12);
      press(10); press(3); chk("disp3", display, 3);
      press(4); chk("disp34", display, 34);
      press(14); chk("disp46", display, 46); chk("a46", a, 46);
      press(14); chk("show_eq_ignored", display, 46);
      @(posedge clk); #1;

      // 7 / 0 = -> error, lockout, clear
      press(15); press(7); press(13); press(0); press(14);
      chk("err_set", error, 1); chk("err_disp", display, 0);
      press(5); press(10); press(14);
      chk("err_hold", error, 1); chk("err_disp_hold", display, 0);
      press(15);
      chk("clr_err", error, 0); chk("clr_a", a, 0); chk("clr_disp", display, 0);
      press(2); chk("after_clr_digit", display, 2);

      // chaining 12 + 3 + 4 =
      press(15); press(1); press(2); press(10); press(3); press(10);
      chk("chain15", display, 15); chk("chain_op", op, 0);
      press(4); press(14); chk("chain19", display, 19);

      // wrap 3 - 5 = then * 2 = from SHOW
      press(15); press(3); press(11); press(5); press(14);
      chk("wrap", display, 65534);
      press(12); press(2); press(14); chk("wrap_mul", display, 65532);
      // SHOW digit restarts entry
      press(8); chk("show_digit", a, 8);

      // overflow drop and leading zeros
      press(15); press(6); press(5); press(5); press(3); press(6);
      chk("ovf_drop", a, 6553);
      press(5); chk("ovf_max", a, 65535);
      press(15); press(0); press(0); press(7); chk("lead0", a, 7);
      // operator replaced before b, then divide with no b -> error
      press(10); press(11); chk("op_replace", op, 1);
      press(13); press(14); chk("div_no_b", error, 1);

      // reset beats a simultaneous key
      press(15); press(9); press(10); press(4);
      rst = 1'b1; key_valid = 1'b1; key_code = 4'd14;
      @(posedge clk);
      model_reset();
      #1 rst = 1'b0; key_valid = 1'b0;
      chk("rstkey_a", a, 0); chk("rstkey_b", b, 0);
      chk("rstkey_op", op, 0); chk("rstkey_disp", display, 0);
      press(3); press(14); chk("rstkey_enter_a", display, 3);

      repeat (3) @(posedge clk);
      #1 check_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
